// File: rtl/mem_io_responder.sv
// mem_io_responder
//
// Memory-side responder for a byte-wide CPU memory bus. The bus has no idle
// encoding, so every clock edge decodes one access. The address is split into
// two regions:
//   - RAM    (mem_a[17:16] != 2'b11): 2**ADDR_WIDTH bytes. Reads are registered,
//     so data is visible one cycle after the address.
//   - I/O    (mem_a[17:16] == 2'b11): decoded on mem_a[2:0]
//       offset 0 write : push into the TX FIFO. A push into a full FIFO is dropped
//                        and sets tx_overflow.
//       offset 0 read  : pop the RX FIFO head. An empty FIFO returns 0x00.
//       offset 4 write : set the sticky halt flag
//       offset 4 read  : status {6'b0, tx_full, rx_nonempty}
//       other offsets  : reads return 0 and writes are ignored
//
// Ports:
//   clk_in, rst_in   clock and asynchronous active-high reset
//   mem_a/mem_wr/    access from the initiator (address, write strobe, write byte)
//   mem_din
//   mem_dout         registered read byte. It is 0 after any write cycle.
//   io_buffer_full   TX count >= TX_DEPTH-2. This leaves room for two writes that
//                    are already in flight.
//   tx_data/valid/   TX FIFO head, using a valid/ready handshake
//   ready
//   rx_data/valid/   RX FIFO input, using a valid/ready handshake
//   ready
//   tx_overflow      sticky: a TX push was dropped
//   halt             sticky: a write to offset 4 was seen
module mem_io_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned TX_DEPTH   = 8,
  parameter int unsigned RX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        tx_overflow,
  output logic        halt
);

  localparam int unsigned TxPw     = $clog2(TX_DEPTH);
  localparam int unsigned RxPw     = $clog2(RX_DEPTH);
  localparam int unsigned RamBytes = 1 << ADDR_WIDTH;

  localparam logic [TxPw:0] TxFullCnt   = (TxPw + 1)'(TX_DEPTH);
  localparam logic [TxPw:0] TxAlmostCnt = (TxPw + 1)'(TX_DEPTH - 2);
  localparam logic [RxPw:0] RxFullCnt   = (RxPw + 1)'(RX_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                  io_sel;
  logic [2:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  unused_addr;

  assign io_sel      = (mem_a[17:16] == 2'b11);
  assign io_off      = mem_a[2:0];
  assign ram_idx     = mem_a[ADDR_WIDTH-1:0];
  assign unused_addr = ^mem_a[31:18];

  logic ram_we;
  logic tx_push_req;
  logic rx_pop_req;
  logic halt_set;

  // A write that coincides with reset is discarded. Without this gate the RAM,
  // which has no reset, would still capture the write.
  assign ram_we      = mem_wr && !io_sel && !rst_in;
  assign tx_push_req = mem_wr && io_sel && (io_off == 3'd0);
  assign rx_pop_req  = !mem_wr && io_sel && (io_off == 3'd0);
  assign halt_set    = mem_wr && io_sel && (io_off == 3'd4);

  // ---------------------------------------------------------------------------
  // RAM storage. Contents survive reset.
  // ---------------------------------------------------------------------------
  logic [7:0] ram_mem [RamBytes];

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= mem_din;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      tx_mem [TX_DEPTH];
  logic [TxPw-1:0] tx_wptr_q, tx_wptr_d;
  logic [TxPw-1:0] tx_rptr_q, tx_rptr_d;
  logic [TxPw:0]   tx_count_q, tx_count_d;
  logic            tx_full;
  logic            tx_pop;
  logic            tx_push;
  logic            tx_drop;

  assign tx_full  = (tx_count_q == TxFullCnt);
  assign tx_valid = (tx_count_q != '0);
  assign tx_data  = tx_mem[tx_rptr_q];
  assign tx_pop   = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign tx_push  = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop  = tx_push_req && tx_full && !tx_pop;

  assign io_buffer_full = (tx_count_q >= TxAlmostCnt);

  always_comb begin
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    tx_count_d = tx_count_q;
    if (tx_push) begin
      tx_wptr_d = tx_wptr_q + TxPw'(1);
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + TxPw'(1);
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + (TxPw + 1)'(1);
      2'b01:   tx_count_d = tx_count_q - (TxPw + 1)'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[tx_wptr_q] <= mem_din;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]      rx_mem [RX_DEPTH];
  logic [RxPw-1:0] rx_wptr_q, rx_wptr_d;
  logic [RxPw-1:0] rx_rptr_q, rx_rptr_d;
  logic [RxPw:0]   rx_count_q, rx_count_d;
  logic            rx_nonempty;
  logic            rx_push;
  logic            rx_pop;

  assign rx_nonempty = (rx_count_q != '0);
  assign rx_ready    = (rx_count_q != RxFullCnt);
  assign rx_push     = rx_valid && rx_ready;
  // When the FIFO is empty, a byte arriving this cycle is not forwarded to the CPU.
  assign rx_pop      = rx_pop_req && rx_nonempty;

  always_comb begin
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    rx_count_d = rx_count_q;
    if (rx_push) begin
      rx_wptr_d = rx_wptr_q + RxPw'(1);
    end
    if (rx_pop) begin
      rx_rptr_d = rx_rptr_q + RxPw'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + (RxPw + 1)'(1);
      2'b01:   rx_count_d = rx_count_q - (RxPw + 1)'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) begin
      rx_mem[rx_wptr_q] <= rx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read data, sticky flags
  // ---------------------------------------------------------------------------
  logic [7:0] mem_dout_q, mem_dout_d;
  logic       tx_overflow_q, tx_overflow_d;
  logic       halt_q, halt_d;

  always_comb begin
    mem_dout_d = '0;
    if (!mem_wr) begin
      if (!io_sel) begin
        mem_dout_d = ram_mem[ram_idx];
      end else begin
        case (io_off)
          3'd0:    mem_dout_d = rx_nonempty ? rx_mem[rx_rptr_q] : 8'h00;
          3'd4:    mem_dout_d = {6'b0, tx_full, rx_nonempty};
          default: mem_dout_d = 8'h00;
        endcase
      end
    end
  end

  assign tx_overflow_d = tx_overflow_q | tx_drop;
  assign halt_d        = halt_q | halt_set;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_dout_q    <= '0;
      tx_overflow_q <= 1'b0;
      halt_q        <= 1'b0;
      tx_wptr_q     <= '0;
      tx_rptr_q     <= '0;
      tx_count_q    <= '0;
      rx_wptr_q     <= '0;
      rx_rptr_q     <= '0;
      rx_count_q    <= '0;
    end else begin
      mem_dout_q    <= mem_dout_d;
      tx_overflow_q <= tx_overflow_d;
      halt_q        <= halt_d;
      tx_wptr_q     <= tx_wptr_d;
      tx_rptr_q     <= tx_rptr_d;
      tx_count_q    <= tx_count_d;
      rx_wptr_q     <= rx_wptr_d;
      rx_rptr_q     <= rx_rptr_d;
      rx_count_q    <= rx_count_d;
    end
  end

  assign mem_dout    = mem_dout_q;
  assign tx_overflow = tx_overflow_q;
  assign halt        = halt_q;

endmodule
